// File: rtl/microwave_defs.sv
// Shared definitions for the microwave cook timer: state encoding, BCD limits
// and the default one-second prescaler length.
package microwave_defs;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADED  = 2'd1,
    RUNNING = 2'd2,
    PAUSED  = 2'd3
  } state_t;

  // Display digits MM:SS, most significant first, so '0 means 00:00.
  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } bcd_time_t;

  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_FIVE = 4'd5;

  localparam int DEFAULT_TICK_DIV = 100;

endpackage

// File: rtl/microwave_timer_tick_gen.sv
// One-second prescaler: counts enabled cycles and emits a one-cycle tick on
// the cycle whose edge wraps the count back to zero.
module tick_gen #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/microwave_timer.sv
// Cook-time countdown: keypad digits shift into MM:SS, the count decrements once
// per second while the magnetron latch is on, and zero time is flagged.
module microwave_timer
  import microwave_defs::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clearn,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       mag_on,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done,
  output logic       done_pulse,
  output logic       running
);

  state_t    state;
  bcd_time_t cnt;
  bcd_time_t cnt_dec;
  bcd_time_t cnt_shift;
  logic      tick;
  logic      tick_en;
  logic      is_zero;
  logic      digit_ok;

  // The prescaler only advances while actually cooking; any other cycle,
  // including a pause or a clear, throws away the partial second.
  assign tick_en = clearn && (state == RUNNING) && mag_on;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .resetn(resetn),
    .en    (tick_en),
    .clr   (!tick_en),
    .tick  (tick)
  );

  assign is_zero  = (cnt == '0);
  assign digit_ok = digit_valid && (digit <= BCD_NINE);

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_dec = cnt;
    if (cnt.sec_ones != '0) begin
      cnt_dec.sec_ones = cnt.sec_ones - 4'd1;
    end else begin
      cnt_dec.sec_ones = BCD_NINE;
      if (cnt.sec_tens != '0) begin
        cnt_dec.sec_tens = cnt.sec_tens - 4'd1;
      end else begin
        cnt_dec.sec_tens = BCD_FIVE;
        if (cnt.min_ones != '0) begin
          cnt_dec.min_ones = cnt.min_ones - 4'd1;
        end else begin
          cnt_dec.min_ones = BCD_NINE;
          cnt_dec.min_tens = cnt.min_tens - 4'd1;
        end
      end
    end
  end

  assign cnt_shift = {cnt.min_ones, cnt.sec_tens, cnt.sec_ones, digit};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (!clearn) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            // A latched magnetron with no time loaded is logic_control's to drop.
            if (!mag_on && digit_ok) begin
              cnt   <= cnt_shift;
              state <= (cnt_shift != '0) ? LOADED : IDLE;
            end
          end
          LOADED: begin
            if (mag_on) begin
              state <= RUNNING;
            end else if (digit_ok) begin
              cnt   <= cnt_shift;
              state <= (cnt_shift != '0) ? LOADED : IDLE;
            end
          end
          RUNNING: begin
            if (!mag_on) begin
              state <= PAUSED;
            end else if (tick && !is_zero) begin
              cnt <= cnt_dec;
              if (cnt_dec == '0) begin
                state      <= IDLE;
                done_pulse <= 1'b1;
              end
            end
          end
          PAUSED: begin
            if (mag_on) begin
              state <= RUNNING;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign min_tens   = cnt.min_tens;
  assign min_ones   = cnt.min_ones;
  assign sec_tens   = cnt.sec_tens;
  assign sec_ones   = cnt.sec_ones;
  assign timer_done = is_zero;
  assign running    = (state == RUNNING);

endmodule

// File: tb/tb_microwave_timer.sv
// Self-checking bench for microwave_timer: directed scenarios followed by
// random keypad/latch/clear traffic, all compared against an arithmetic model.
module tb_microwave_timer;

  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic       clearn;
  logic       digit_valid;
  logic [3:0] digit;
  logic       mag_on;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       timer_done, done_pulse, running;

  always #5 clk = ~clk;

  microwave_timer #(.TICK_DIV(TICK_DIV)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .clearn     (clearn),
    .digit_valid(digit_valid),
    .digit      (digit),
    .mag_on     (mag_on),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .timer_done (timer_done),
    .done_pulse (done_pulse),
    .running    (running)
  );

  int    checks = 0;
  int    errors = 0;
  string phase  = "reset";

  // Reference model: minutes and seconds as plain integers, cooking flags and
  // a count of cooking cycles since the last whole second.
  int m_mm, m_ss, m_sub;
  bit m_run, m_pause, m_pulse;

  function automatic int m_val();
    return m_mm * 100 + m_ss;
  endfunction

  function automatic logic [15:0] m_disp();
    return {4'(m_mm / 10), 4'(m_mm % 10), 4'(m_ss / 10), 4'(m_ss % 10)};
  endfunction

  function automatic logic [15:0] disp();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic model_reset();
    m_mm = 0; m_ss = 0; m_sub = 0;
    m_run = 0; m_pause = 0; m_pulse = 0;
  endtask

  task automatic model_step(input bit cl, input bit dv, input int d, input bit mag);
    int v;
    m_pulse = 0;
    if (!cl) begin
      m_mm = 0; m_ss = 0; m_sub = 0; m_run = 0; m_pause = 0;
    end else if (m_run) begin
      if (!mag) begin
        m_run = 0; m_pause = 1; m_sub = 0;
      end else begin
        m_sub++;
        if (m_sub == TICK_DIV) begin
          m_sub = 0;
          if (m_ss > 0) m_ss--;
          else if (m_mm > 0) begin m_mm--; m_ss = 59; end
          if (m_val() == 0) begin m_run = 0; m_pulse = 1; end
        end
      end
    end else if (m_pause) begin
      if (mag) begin m_pause = 0; m_run = 1; m_sub = 0; end
    end else if (mag) begin
      if (m_val() != 0) begin m_run = 1; m_sub = 0; end
    end else if (dv && d <= 9) begin
      v = (m_val() * 10 + d) % 10000;
      m_mm = v / 100;
      m_ss = v % 100;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed %h expected %h", phase, tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("disp",       disp(),             m_disp());
    check("timer_done", 16'(timer_done),    16'(m_val() == 0));
    check("done_pulse", 16'(done_pulse),    16'(m_pulse));
    check("running",    16'(running),       16'(m_run));
  endtask

  task automatic step(input bit cl, input bit dv, input logic [3:0] d, input bit mag);
    clearn = cl; digit_valid = dv; digit = d; mag_on = mag;
    @(posedge clk);
    model_step(cl, dv, int'(d), mag);
    #1;
    compare_all();
  endtask

  task automatic key(input logic [3:0] d);
    step(1'b1, 1'b1, d, 1'b0);
  endtask

  task automatic cook(input int n, input bit mag);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'd0, mag);
  endtask

  task automatic clear();
    step(1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    bit cl, dv, mag;
    logic [3:0] d;

    resetn = 1'b0; clearn = 1'b1; digit_valid = 1'b0; digit = 4'd0; mag_on = 1'b0;
    model_reset();
    #12;
    check("rst_disp", disp(), 16'h0000);
    check("rst_done", 16'(timer_done), 16'd1);
    check("rst_pulse", 16'(done_pulse), 16'd0);
    check("rst_run", 16'(running), 16'd0);
    resetn = 1'b1;

    phase = "entry";
    key(4'd0); key(4'd1); key(4'd3); key(4'd0);
    check("disp_0130", disp(), 16'h0130);
    check("loaded_done", 16'(timer_done), 16'd0);
    check("loaded_run", 16'(running), 16'd0);

    phase = "countdown";
    clear();
    key(4'd0); key(4'd0); key(4'd0); key(4'd2);
    cook(1, 1'b1);
    check("started", 16'(running), 16'd1);
    cook(4, 1'b1);
    check("disp_0001", disp(), 16'h0001);
    cook(4, 1'b1);
    check("disp_0000", disp(), 16'h0000);
    check("pulse_hi", 16'(done_pulse), 16'd1);
    check("done_hi", 16'(timer_done), 16'd1);
    check("idle_run", 16'(running), 16'd0);
    cook(1, 1'b1);
    check("pulse_lo", 16'(done_pulse), 16'd0);

    phase = "borrow";
    clear();
    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    cook(5, 1'b1);
    check("disp_0959", disp(), 16'h0959);
    clear();
    key(4'd0); key(4'd1); key(4'd7); key(4'd5);
    cook(5, 1'b1);
    check("disp_0174", disp(), 16'h0174);

    phase = "pause";
    clear();
    key(4'd0); key(4'd0); key(4'd0); key(4'd5);
    cook(6, 1'b1);
    check("disp_0004", disp(), 16'h0004);
    cook(3, 1'b0);
    check("paused_disp", disp(), 16'h0004);
    check("paused_run", 16'(running), 16'd0);
    cook(1, 1'b1);
    check("resumed", 16'(running), 16'd1);
    cook(3, 1'b1);
    check("no_early", disp(), 16'h0004);
    cook(1, 1'b1);
    check("disp_0003", disp(), 16'h0003);

    phase = "ignore";
    step(1'b1, 1'b1, 4'd7, 1'b1);
    check("run_key", disp(), 16'h0003);
    clear();
    key(4'd1); key(4'd2);
    key(4'hC);
    check("bad_digit", disp(), 16'h0012);
    cook(4, 1'b1);
    step(1'b0, 1'b0, 4'd0, 1'b1);
    check("clr_tick_disp", disp(), 16'h0000);
    check("clr_tick_pulse", 16'(done_pulse), 16'd0);
    check("clr_tick_run", 16'(running), 16'd0);

    phase = "async";
    key(4'd5);
    cook(9, 1'b1);
    check("disp_0003b", disp(), 16'h0003);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    check("async_disp", disp(), 16'h0000);
    check("async_done", 16'(timer_done), 16'd1);
    check("async_run", 16'(running), 16'd0);
    #2 resetn = 1'b1;
    mag_on = 1'b0;
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    check("disp_2345", disp(), 16'h2345);

    phase = "random";
    clear();
    mag = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      cl = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 11) == 0) mag = !mag;
      dv = !mag && ($urandom_range(0, 2) == 0);
      d  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      step(cl, dv, d, mag);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/microwave_timer.md
Name: microwave_timer

Overview:
- Cook-time countdown timer for the microwave controller. It produces the timer_done input consumed by logic_control.
- Keypad digits are shifted in as four BCD digits MM:SS.
- Counts down once per second while the magnetron latch output (mag_on) is high. Flags zero time to logic_control and to the beeper.

Parameters:
- TICK_DIV, 100, clk cycles per one-second tick (kept small for simulation).

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- clearn  input  1  keypad clear, active-low, sampled synchronously.
- digit_valid  input  1  one-cycle strobe: digit is valid.
- digit  input  4  BCD keypad digit.
- mag_on  input  1  magnetron latch Q. High means cooking.
- min_tens  output  4  display digit.
- min_ones  output  4  display digit.
- sec_tens  output  4  display digit.
- sec_ones  output  4  display digit.
- timer_done  output  1  high whenever all four digits are zero.
- done_pulse  output  1  one-cycle pulse when a countdown reaches 00:00.
- running  output  1  high in state RUNNING.

Behaviour:
- Reset (resetn=0, asynchronous):
  - All digits 0, prescaler 0, state IDLE.
  - timer_done=1, done_pulse=0, running=0.
- States: IDLE (count zero), LOADED (nonzero, never started), RUNNING, PAUSED.
- Priority per cycle: clearn=0, then countdown/mag_on, then digit entry.
- clearn=0, in any state: next cycle all digits are 0, prescaler is 0, state is IDLE. No done_pulse.
- Digit entry (digit_valid=1, digit<=9, state IDLE or LOADED):
  - Left shift: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit.
  - The oldest digit is discarded after 4 entries.
  - The next state is LOADED if the result is nonzero, otherwise IDLE.
- Digit entry is ignored when digit>9, or when the state is RUNNING or PAUSED.
- Entered values are not normalised. 01:75 is accepted and counts 75 down to 00, then continues from 00:59.
- State transitions:
  - LOADED or PAUSED with mag_on=1 -> RUNNING.
  - RUNNING with mag_on=0 -> PAUSED. No decrement in that cycle, even if a tick coincides.
  - IDLE with mag_on=1: stays IDLE. logic_control is responsible for dropping the latch.
- Prescaler:
  - Increments every cycle in RUNNING while mag_on=1.
  - Held at 0 in all other states. A pause discards the partial second.
  - At TICK_DIV-1 it wraps to 0 and the BCD count decrements by one second.
  - The first decrement therefore lands TICK_DIV cycles after the first RUNNING cycle.
- Decrement rules:
  - sec_ones 0 -> 9 with a borrow into sec_tens.
  - sec_tens 0 -> 5 with a borrow into minutes.
  - min_ones 0 -> 9 with a borrow into min_tens.
  - A decrement is never applied at 00:00.
- Decrement to 00:00:
  - The same edge sets state IDLE and done_pulse=1 for exactly one cycle.
  - timer_done rises together with the zero count.
- timer_done is a combinational decode of the digit registers, so there is no extra latency. running decodes the state register.
- Simultaneous events:
  - clearn=0 with a tick: clear wins and no done_pulse is generated.
  - digit_valid during RUNNING or PAUSED: ignored.
  - Asynchronous reset mid-count: immediate return to the reset values.

Decomposition:
- Shared header microwave_defs:
  - State encoding localparams: IDLE=2'd0, LOADED=2'd1, RUNNING=2'd2, PAUSED=2'd3.
  - BCD limit constants (9, 5).
  - Default TICK_DIV.
- One sub-module, tick_gen:
  - Parameterised prescaler with enable input, synchronous clear and one-cycle tick output.
- BCD borrow chain and FSM stay in microwave_timer.

Test Plan:
1. Reset, then enter digits 0,1,3,0 -> display 01:30, state LOADED, timer_done=0, running=0.
2. TICK_DIV=4, load 00:02, hold mag_on=1:
   - 00:01 after 4 cycles, 00:00 after 8 cycles.
   - done_pulse high for 1 cycle on that edge.
   - timer_done=1 and state IDLE.
3. Borrow chain, load 10:00 and tick once -> 09:59. Load 01:75 and tick once -> 01:74.
4. Pause/resume:
   - Load 00:05 and run 6 cycles (one decrement, to 00:04).
   - Drop mag_on for 3 cycles -> PAUSED, display frozen at 00:04, prescaler 0.
   - Raise mag_on -> next decrement 4 cycles later.
5. Clear and ignore rules:
   - digit_valid with digit=7 while RUNNING -> display unchanged.
   - digit=4'hC in LOADED -> ignored.
   - clearn=0 coincident with a tick -> 00:00, IDLE, done_pulse=0.
6. Async reset mid-run at 00:03 -> outputs at reset values within the same cycle, before the next clk edge. A 5th digit entry drops min_tens: entering 1,2,3,4,5 gives 23:45.
